sccb_target: RTL and testbench

//  SCCB/I2C-style target (responder). Models the OV7670 register port on the far end of our SCCB master.

---
 rtl/sccb_pkg.sv | 8 +
 rtl/sccb_sync_edge.sv | 37 +++
 rtl/sccb_target.sv | 116 +++++++++++
 tb/tb_sccb_target.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared SCCB target state encoding and bus constants
package sccb_pkg;
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
  } sccb_tgt_state_e;
  localparam logic [7:0] SCCB_ID_OV7670 = 8'h42;
  localparam int SCCB_RD_BIT = 0;
endpackage

// File: rtl/sccb_sync_edge.sv
// sccb_sync_edge: synchronizes scl/sda and flags scl edges plus START/STOP
module sccb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_s, scl_prev, sda_prev;
  // idle bus is high, so sync stages reset high to avoid phantom edges
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      scl_q    <= '1;
      sda_q    <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_q    <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q    <= {sda_q[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end
  assign scl_s     = scl_q[SYNC_STAGES-1];
  assign sda_s     = sda_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder decoding 3-phase writes and 2-phase reads into a 256x8 register file
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = SCCB_ID_OV7670,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  localparam logic [7:0] RD_ID = DEV_ID | (8'd1 << SCCB_RD_BIT);
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  sccb_tgt_state_e state, state_n;
  logic [7:0] sh, addr_ptr, byte_val;
  logic [7:0] regfile [256];
  logic [3:0] bit_cnt;
  logic rd, byte_done, ack_end;
  sccb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .scl(scl),
    .sda_in(sda_in),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start_det(start_det),
    .stop_det(stop_det),
    .sda_s(sda_s)
  );
  assign byte_val  = {sh[6:0], sda_s};
  assign byte_done = scl_rise && bit_cnt == 4'd7;
  // ACK slots use bit_cnt 8 (waiting to assert) and 9 (waiting to release)
  assign ack_end   = scl_fall && bit_cnt == 4'd9;
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (stop_det) state_n = IDLE;
    else if (start_det) state_n = ID;
    else
      case (state)
        ID:        if (byte_done) state_n = (byte_val == DEV_ID || byte_val == RD_ID) ? ID_ACK : IGNORE;
        ID_ACK:    if (ack_end) state_n = rd ? RDATA : ADDR;
        ADDR:      if (byte_done) state_n = ADDR_ACK;
        ADDR_ACK:  if (ack_end) state_n = WDATA;
        WDATA:     if (byte_done) state_n = WDATA_ACK;
        WDATA_ACK: if (ack_end) state_n = WDATA;
        RDATA:     if (scl_fall && bit_cnt == 4'd8) state_n = RD_ACK;
        RD_ACK:    state_n = (scl_rise && sda_s) ? IGNORE : (scl_fall && bit_cnt == 4'd8) ? RDATA : RD_ACK;
        default:   state_n = state;
      endcase
  end
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      addr_ptr  <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      rd        <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det || start_det) begin
        busy    <= start_det;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else if (scl_rise) begin
        if (state inside {ID, ADDR, WDATA, RDATA}) bit_cnt <= bit_cnt + 4'd1;
        if (state inside {ID, ADDR, WDATA}) sh <= byte_val;
        if (byte_done && state == ID) begin
          rd <= byte_val == RD_ID;
          if (byte_val == RD_ID) sh <= regfile[addr_ptr];
        end
        if (byte_done && state == ADDR) addr_ptr <= byte_val;
        if (byte_done && state == WDATA) begin
          wr_strobe <= 1'b1;
          wr_addr   <= addr_ptr;
          wr_data   <= byte_val;
          addr_ptr  <= addr_ptr + 8'd1;
        end
        if (state == RD_ACK && !sda_s) begin
          addr_ptr <= addr_ptr + 8'd1;
          sh       <= regfile[addr_ptr + 8'd1];
          bit_cnt  <= 4'd8;
        end
      end else if (scl_fall) begin
        // the fall that ends a read ID's ACK also presents the first data bit
        if (state inside {ID_ACK, ADDR_ACK, WDATA_ACK}) begin
          sda_oe  <= bit_cnt == 4'd8 || (state == ID_ACK && rd && !sh[7]);
          bit_cnt <= bit_cnt == 4'd8 ? 4'd9 : 4'd0;
        end
        if (state == RDATA) begin
          sda_oe <= bit_cnt != 4'd8 && !sh[3'd7 - bit_cnt[2:0]];
          if (bit_cnt == 4'd8) bit_cnt <= '0;
        end
        if (state == RD_ACK && bit_cnt == 4'd8) begin
          sda_oe  <= !sh[7];
          bit_cnt <= '0;
        end
      end
    end
  end
  always_ff @(posedge clk_100MHz)
    if (state == WDATA && byte_done) regfile[addr_ptr] <= byte_val;
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bit-banged SCCB master with open-drain resolve and a register-file reference model
module tb_sccb_target;
  localparam int H = 24;
  localparam int Q = 6;
  logic clk_100MHz = 1'b0, reset = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic sda_in, sda_oe, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data;
  assign sda_in = sda_m & ~sda_oe;
  always #5 clk_100MHz = ~clk_100MHz;
  sccb_target dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .scl(scl),
    .sda_in(sda_in),
    .sda_oe(sda_oe),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy)
  );
  int tests = 0, fails = 0;
  logic [7:0] mem [256];
  bit valid [256];
  logic [7:0] ptr = 8'h00;
  logic [15:0] exp_q[$], obs_q[$];
  int obs_rd = 0, oe_cnt = 0;
  always @(negedge clk_100MHz) begin
    if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wt(input int n);
    repeat (n) @(posedge clk_100MHz);
  endtask
  task automatic bitc(input logic b, output logic s);
    wt(Q); sda_m = b; wt(H - Q); scl = 1'b1; wt(H / 2); s = sda_in; wt(H - H / 2); scl = 1'b0;
  endtask
  task automatic start_c;
    wt(Q); sda_m = 1'b1; wt(H - Q); scl = 1'b1; wt(H); sda_m = 1'b0; wt(H); scl = 1'b0;
  endtask
  task automatic stop_c;
    wt(Q); sda_m = 1'b0; wt(H - Q); scl = 1'b1; wt(H); sda_m = 1'b1; wt(H);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bitc(b[i], s);
    bitc(1'b1, s);
    ack = ~s;
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bitc(1'b1, s);
      b[i] = s;
    end
    bitc(nack, s);
  endtask
  task automatic check_strobes(input string tag);
    int n;
    n = obs_q.size() - obs_rd;
    chk({tag, " strobe_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) chk({tag, " strobe"}, obs_q[obs_rd + i], exp_q[i]);
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask
  // bytes d[7:0] first; n data bytes after the address (n=0 is a 2-phase pointer set)
  task automatic write_tx(input logic [7:0] id, input logic [7:0] addr, input logic [31:0] d,
                          input int n, input bit ok, input string tag);
    logic a;
    logic [5:0] acks;
    int oe0;
    acks = '0;
    oe0 = oe_cnt;
    start_c;
    send_byte(id, a); acks[0] = a;
    send_byte(addr, a); acks[1] = a;
    for (int i = 0; i < n; i++) begin
      send_byte(d[8*i +: 8], a);
      acks[i + 2] = a;
    end
    chk({tag, " busy"}, busy, 1);
    stop_c;
    chk({tag, " busy_after_stop"}, busy, 0);
    chk({tag, " acks"}, acks, ok ? (6'd1 << (n + 2)) - 6'd1 : 6'd0);
    chk({tag, " oe_seen"}, oe_cnt != oe0, ok);
    if (ok) begin
      ptr = addr;
      for (int i = 0; i < n; i++) begin
        mem[ptr] = d[8*i +: 8];
        valid[ptr] = 1'b1;
        exp_q.push_back({ptr, d[8*i +: 8]});
        ptr = ptr + 8'd1;
      end
    end
    check_strobes(tag);
  endtask
  task automatic read_tx(input int n, input string tag);
    logic a;
    logic [7:0] b;
    start_c;
    send_byte(8'h43, a);
    chk({tag, " rd_id_ack"}, a, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      if (valid[ptr]) chk({tag, " rdata"}, b, mem[ptr]);
      if (i < n - 1) ptr = ptr + 8'd1;
    end
    chk({tag, " rd_release"}, sda_oe, 0);
    stop_c;
    chk({tag, " rd_busy_after_stop"}, busy, 0);
    check_strobes(tag);
  endtask
  typedef struct {
    logic [7:0]  id;
    logic [7:0]  addr;
    logic [31:0] d;
    int          n;
    bit          ok;
  } vec_t;
  vec_t tv [6];
  initial begin
    logic a;
    logic s;
    logic [7:0] id, addr;
    tv[0] = '{8'h42, 8'h12, 32'h80, 1, 1'b1};
    tv[1] = '{8'h40, 8'h12, 32'h7E, 1, 1'b0};
    tv[2] = '{8'h42, 8'h00, 32'h5AFF, 2, 1'b1};
    tv[3] = '{8'hC2, 8'h12, 32'h11, 1, 1'b0};
    tv[4] = '{8'h42, 8'h3A, 32'h04, 1, 1'b1};
    tv[5] = '{8'h42, 8'h3A, 32'h00, 0, 1'b1};
    wt(4);
    reset = 1'b0;
    wt(2);
    chk("reset sda_oe", sda_oe, 0);
    chk("reset wr_strobe", wr_strobe, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset busy", busy, 0);
    for (int i = 0; i < 6; i++) write_tx(tv[i].id, tv[i].addr, tv[i].d, tv[i].n, tv[i].ok, $sformatf("vec%0d", i));
    read_tx(1, "t3 read");
    write_tx(8'h42, 8'h12, 32'h0, 0, 1'b1, "t2 ptr");
    read_tx(1, "t2 read");
    write_tx(8'h42, 8'hFF, 32'hBBAA, 2, 1'b1, "t4 wr");
    write_tx(8'h42, 8'hFF, 32'h0, 0, 1'b1, "t4 ptr");
    read_tx(2, "t4 read");
    // repeated START four bits into a data byte
    start_c;
    send_byte(8'h42, a); chk("t5 id_ack", a, 1);
    send_byte(8'h30, a); chk("t5 addr_ack", a, 1);
    bitc(1'b1, s); bitc(1'b0, s); bitc(1'b1, s); bitc(1'b1, s);
    chk("t5 busy_mid", busy, 1);
    write_tx(8'h42, 8'h20, 32'h55, 1, 1'b1, "t5 wr");
    // reset pulse while the target holds the address ACK low
    start_c;
    send_byte(8'h42, a); chk("t6 id_ack", a, 1);
    for (int i = 7; i >= 0; i--) bitc(i == 4 || i == 0, s);
    wt(Q); sda_m = 1'b1; wt(H - Q); scl = 1'b1; wt(H / 2);
    chk("t6 oe_in_ack", sda_oe, 1);
    #1 reset = 1'b1;
    #1 chk("t6 oe_async_reset", sda_oe, 0);
    chk("t6 busy_reset", busy, 0);
    wt(3);
    reset = 1'b0;
    ptr = 8'h00;
    wt(H / 2); scl = 1'b0;
    stop_c;
    write_tx(8'h42, 8'h11, 32'h80, 1, 1'b1, "t6 wr");
    write_tx(8'h42, 8'h11, 32'h0, 0, 1'b1, "t6 ptr");
    read_tx(1, "t6 read");
    for (int k = 0; k < 10; k++) begin
      int op, n;
      op = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      addr = 8'hFC + 8'($urandom_range(0, 7));
      if (op < 2) write_tx(8'h42, addr, $urandom, n, 1'b1, "rnd wr");
      else if (op == 2) begin
        id = 8'h42 ^ (8'd1 << $urandom_range(1, 7));
        write_tx(id, addr, $urandom, n, 1'b0, "rnd badid");
      end else begin
        write_tx(8'h42, addr, 32'h0, 0, 1'b1, "rnd ptr");
        read_tx(n, "rnd read");
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
